// File: rtl/serial_test_pkg.sv
// Shared types and default widths for the serial test master and its target instantiations.
package serial_test_pkg;

    localparam int unsigned DefInBits  = 6;
    localparam int unsigned DefOutBits = 4;

    typedef enum logic [2:0] {
        StIdle,
        StInRst,
        StShift,
        StSettle,
        StOutRst,
        StGap,
        StAdv,
        StDone
    } state_e;

endpackage

// File: rtl/ser_pulse_timer.sv
// Half-period timer for serial clock pulses: low phase then high phase, restarted by go.
module ser_pulse_timer #(
    parameter int unsigned HALF_PERIOD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic go,
    output logic sclk,
    output logic half_done,
    output logic phase_done
);

    localparam int unsigned     CntW    = $clog2(HALF_PERIOD);
    localparam logic [CntW-1:0] CntLast = CntW'(HALF_PERIOD - 1);

    logic [CntW-1:0] cnt_q;
    logic            sclk_q;

    // go forces a fresh low phase starting next cycle, whatever the timer was doing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (go) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (cnt_q == CntLast) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign sclk       = sclk_q;
    assign half_done  = (cnt_q == CntLast);
    assign phase_done = half_done && sclk_q;

endmodule

// File: rtl/serial_test_master.sv
// Host-side driver for the bit-serial test port: reset+shift a vector in, settle, read result back.
module serial_test_master
    import serial_test_pkg::*;
#(
    parameter int unsigned IN_BITS       = DefInBits,
    parameter int unsigned OUT_BITS      = DefOutBits,
    parameter int unsigned HALF_PERIOD   = 4,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [IN_BITS-1:0]  vector,
    output logic                busy,
    output logic                done,
    output logic [OUT_BITS-1:0] result,
    output logic                ser_in_clk,
    output logic                ser_in_data,
    output logic                ser_in_rst,
    output logic                ser_out_clk,
    output logic                ser_out_rst,
    input  logic                ser_out_data
);

    localparam int unsigned MaxBits = (IN_BITS > OUT_BITS) ? IN_BITS : OUT_BITS;
    localparam int unsigned IdxW    = (MaxBits > 1) ? $clog2(MaxBits) : 1;
    localparam int unsigned SetW    = $clog2(SETTLE_CYCLES + 1);

    localparam logic [IdxW-1:0] InLast     = IdxW'(IN_BITS - 1);
    localparam logic [IdxW-1:0] OutLast    = IdxW'(OUT_BITS - 1);
    localparam logic [SetW-1:0] SettleLast = SetW'(SETTLE_CYCLES - 1);

    state_e              state_q;
    logic [IN_BITS-1:0]  shreg_q;
    logic [OUT_BITS-1:0] shadow_q;
    logic [IdxW-1:0]     bit_idx_q;
    logic [SetW-1:0]     settle_q;
    logic [1:0]          sync_q;

    logic timer_go;
    logic sclk;
    logic half_done;
    logic phase_done;

    ser_pulse_timer #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .go         (timer_go),
        .sclk       (sclk),
        .half_done  (half_done),
        .phase_done (phase_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], ser_out_data};
        end
    end

    // Restart the timer on every entry into a timed state so each pulse/gap starts low.
    always_comb begin
        timer_go = 1'b0;
        case (state_q)
            StIdle:                   timer_go = start;
            StInRst, StOutRst, StAdv: timer_go = phase_done;
            StShift:                  timer_go = phase_done && (bit_idx_q != InLast);
            StSettle:                 timer_go = (settle_q == SettleLast);
            StGap:                    timer_go = half_done && !sclk && (bit_idx_q != OutLast);
            default:                  timer_go = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            shadow_q    <= '0;
            bit_idx_q   <= '0;
            settle_q    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            ser_in_clk  <= 1'b0;
            ser_in_data <= 1'b0;
            ser_in_rst  <= 1'b0;
            ser_out_clk <= 1'b0;
            ser_out_rst <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StInRst;
                        shreg_q     <= vector;
                        busy        <= 1'b1;
                        ser_in_rst  <= 1'b1;
                        ser_in_data <= 1'b0;
                    end
                end
                StInRst: begin
                    if (phase_done) begin
                        state_q     <= StShift;
                        ser_in_clk  <= 1'b0;
                        ser_in_rst  <= 1'b0;
                        ser_in_data <= shreg_q[0];
                        shreg_q     <= shreg_q >> 1;
                        bit_idx_q   <= '0;
                    end else if (half_done) begin
                        ser_in_clk <= 1'b1;
                    end
                end
                StShift: begin
                    if (phase_done) begin
                        ser_in_clk <= 1'b0;
                        if (bit_idx_q == InLast) begin
                            state_q     <= StSettle;
                            ser_in_data <= 1'b0;
                            settle_q    <= '0;
                        end else begin
                            ser_in_data <= shreg_q[0];
                            shreg_q     <= shreg_q >> 1;
                            bit_idx_q   <= bit_idx_q + 1'b1;
                        end
                    end else if (half_done) begin
                        ser_in_clk <= 1'b1;
                    end
                end
                StSettle: begin
                    if (settle_q == SettleLast) begin
                        state_q     <= StOutRst;
                        ser_out_rst <= 1'b1;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                StOutRst: begin
                    if (phase_done) begin
                        state_q     <= StGap;
                        ser_out_clk <= 1'b0;
                        ser_out_rst <= 1'b0;
                        bit_idx_q   <= '0;
                    end else if (half_done) begin
                        ser_out_clk <= 1'b1;
                    end
                end
                StGap: begin
                    // Bits arrive LSB first, so shift in from the top.
                    if (half_done) begin
                        shadow_q <= {sync_q[1], shadow_q[OUT_BITS-1:1]};
                        if (bit_idx_q == OutLast) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            result  <= {sync_q[1], shadow_q[OUT_BITS-1:1]};
                        end else begin
                            state_q <= StAdv;
                        end
                    end
                end
                StAdv: begin
                    if (phase_done) begin
                        state_q     <= StGap;
                        ser_out_clk <= 1'b0;
                        bit_idx_q   <= bit_idx_q + 1'b1;
                    end else if (half_done) begin
                        ser_out_clk <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_test_master.sv
// Scoreboard bench for serial_test_master driving a behavioural loopback target.
module tb_serial_test_master;
    import serial_test_pkg::*;

    localparam int unsigned IN_BITS  = DefInBits;
    localparam int unsigned OUT_BITS = DefOutBits;
    localparam int unsigned H        = 4;
    localparam int unsigned SETTLE   = 16;
    localparam int unsigned LAT      = 1 + 2 * H * (IN_BITS + 2) + SETTLE + OUT_BITS * H
                                       + (OUT_BITS - 1) * 2 * H;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [IN_BITS-1:0]  vector = '0;
    logic                busy;
    logic                done;
    logic [OUT_BITS-1:0] result;
    logic                ser_in_clk;
    logic                ser_in_data;
    logic                ser_in_rst;
    logic                ser_out_clk;
    logic                ser_out_rst;
    logic                ser_out_data;

    serial_test_master #(
        .IN_BITS       (IN_BITS),
        .OUT_BITS      (OUT_BITS),
        .HALF_PERIOD   (H),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .vector       (vector),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .ser_in_clk   (ser_in_clk),
        .ser_in_data  (ser_in_data),
        .ser_in_rst   (ser_in_rst),
        .ser_out_clk  (ser_out_clk),
        .ser_out_rst  (ser_out_rst),
        .ser_out_data (ser_out_data)
    );

    always #5 clk = ~clk;

    // Loopback target: outputs = inputs[OUT_BITS-1:0], read back LSB first.
    logic [IN_BITS-1:0]  tgt_in  = '0;
    logic [OUT_BITS-1:0] tgt_out = '0;
    assign ser_out_data = tgt_out[0];

    initial forever begin
        @(posedge ser_in_clk);
        if (ser_in_rst) tgt_in = '0;
        else            tgt_in = {ser_in_data, tgt_in[IN_BITS-1:1]};
    end

    initial forever begin
        @(posedge ser_out_clk);
        if (ser_out_rst) tgt_out = tgt_in[OUT_BITS-1:0];
        else             tgt_out = tgt_out >> 1;
    end

    typedef struct {
        logic [OUT_BITS-1:0] res;
        int unsigned         done_cyc;
    } exp_t;

    exp_t                sb[$];
    int unsigned         cyc       = 0;
    int unsigned         busy_lo   = 1;
    int unsigned         busy_hi   = 0;
    int unsigned         free_from = 0;
    int unsigned         rst_cyc   = 32'hffff_ffff;
    logic [IN_BITS-1:0]  cur_vec   = '0;
    logic [OUT_BITS-1:0] exp_result = '0;
    int                  n_tests = 0;
    int                  n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the master accepts start only when idle, and answers LAT cycles later.
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        if (!rst_n) begin
            sb.delete();
            busy_lo    = 1;
            busy_hi    = 0;
            free_from  = cyc + 1;
            rst_cyc    = cyc;
            exp_result = '0;
        end else if (start && cyc >= free_from) begin
            sb.push_back('{res: vector[OUT_BITS-1:0], done_cyc: cyc + LAT - 1});
            busy_lo   = cyc;
            busy_hi   = cyc + LAT - 2;
            free_from = cyc + LAT + 1;
            cur_vec   = vector;
        end
    end

    // Monitor: outputs checked on the falling edge against the model.
    initial begin
        int unsigned in_edges  = 0;
        int unsigned out_edges = 0;
        int unsigned stab      = 0;
        logic        p_in_clk  = 1'b0;
        logic        p_out_clk = 1'b0;
        logic        p_data    = 1'b0;
        logic        p_rst     = 1'b0;
        logic        exp_done;
        forever begin
            @(negedge clk);
            if (rst_cyc == cyc) begin
                check("rst_ser_in_clk", 32'(ser_in_clk), 32'd0);
                check("rst_ser_in_data", 32'(ser_in_data), 32'd0);
                check("rst_ser_in_rst", 32'(ser_in_rst), 32'd0);
                check("rst_ser_out_clk", 32'(ser_out_clk), 32'd0);
                check("rst_ser_out_rst", 32'(ser_out_rst), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_result", 32'(result), 32'd0);
                in_edges  = 0;
                out_edges = 0;
            end else begin
                exp_done = (sb.size() > 0) && (sb[0].done_cyc == cyc);
                check("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
                check("done", 32'(done), 32'(exp_done));
                if (exp_done) begin
                    exp_result = sb[0].res;
                    void'(sb.pop_front());
                    check("in_clk_edges", in_edges, IN_BITS + 1);
                    check("out_clk_edges", out_edges, OUT_BITS);
                    in_edges  = 0;
                    out_edges = 0;
                end
                check("result", 32'(result), 32'(exp_result));
                if (ser_in_data != p_data || ser_in_rst != p_rst) stab = 0;
                else stab++;
                if (ser_in_clk && !p_in_clk) begin
                    in_edges++;
                    check("in_setup", 32'(stab >= H), 32'd1);
                    check("in_rst_edge", 32'(ser_in_rst), 32'(in_edges == 1));
                    if (in_edges >= 2 && in_edges <= IN_BITS + 1)
                        check("in_data_bit", 32'(ser_in_data),
                              32'(cur_vec >> (in_edges - 2)) & 32'd1);
                end
                if (ser_out_clk && !p_out_clk) begin
                    out_edges++;
                    check("out_rst_edge", 32'(ser_out_rst), 32'(out_edges == 1));
                end
            end
            p_in_clk  = ser_in_clk;
            p_out_clk = ser_out_clk;
            p_data    = ser_in_data;
            p_rst     = ser_in_rst;
        end
    end

    task automatic issue(input logic [IN_BITS-1:0] v);
        vector = v;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Waits for done; optionally steps one more cycle so the next start lands in IDLE.
    task automatic wait_done(input int unsigned max_cyc, input bit advance);
        bit seen = 1'b0;
        for (int i = 0; i < int'(max_cyc); i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_done: no done within %0d cycles, expected one", max_cyc);
        end
        if (advance) @(negedge clk);
    endtask

    initial begin
        logic [IN_BITS-1:0] v;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed loopback
        issue(6'b101101);
        wait_done(LAT + 10, 1'b1);

        // Back-to-back: start held from the done cycle
        issue(IN_BITS'($urandom));
        wait_done(LAT + 10, 1'b0);
        vector = IN_BITS'($urandom);
        start  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start  = 1'b0;
        wait_done(LAT + 10, 1'b1);

        // Start while busy is ignored
        v = 6'b010011;
        issue(v);
        repeat (39) @(negedge clk);
        issue(~v);
        wait_done(LAT + 10, 1'b1);

        // Reset mid-SHIFT, then a fresh transaction
        issue(6'b110110);
        repeat (28) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(6'b101101);
        wait_done(LAT + 10, 1'b1);

        // Randomized transactions with occasional start while busy
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(IN_BITS'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(5, 100)) @(negedge clk);
                issue(IN_BITS'($urandom));
            end
            wait_done(LAT + 10, 1'b1);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
